// File: rtl/backbone_pkg.sv
// Shared definitions for the backbone_J collector: FSM encoding and sizing helpers.
package backbone_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    FILL = 2'b01,
    HOLD = 2'b10
  } state_e;

  localparam int DEFAULT_DATAWIDTH = 32;

  // Wide enough to count 0..J so the fill index never wraps silently.
  function automatic int idxWidth(input int j);
    return $clog2(j) + 1;
  endfunction

endpackage

// File: rtl/backbone_j_collect.sv
// Collects the J-1 backbone_J words of one frame into a packed vector and hands it
// downstream over a valid/ready handshake, flagging dropped words and cut-short frames.
module backbone_j_collect
  import backbone_pkg::*;
#(
  parameter int J         = 14,
  parameter int DATAWIDTH = DEFAULT_DATAWIDTH,
  localparam int IDX_WIDTH = idxWidth(J)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         frame_start,
  input  logic                         backbone_J_tvalid,
  input  logic [DATAWIDTH-1:0]         backbone_J,
  output logic [(J-1)*DATAWIDTH-1:0]   backbone_J_vec,
  output logic                         backbone_J_vec_tvalid,
  input  logic                         backbone_J_vec_tready,
  output logic [IDX_WIDTH-1:0]         fill_idx,
  output logic                         overrun,
  output logic                         short_frame
);

  localparam int N = J - 1;
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(N - 1);

  state_e                 state_q;
  logic [IDX_WIDTH-1:0]   fillIdx_q;
  logic                   vecValid_q;
  logic                   overrun_q;
  logic                   shortFrame_q;
  logic                   pendingStart_q;
  logic [DATAWIDTH-1:0]   slot_q [N];

  logic                   handshake;
  logic                   wrEn;
  logic [IDX_WIDTH-1:0]   wrIdx;

  // A frame_start always restarts at slot 0, even when it carries the first word.
  always_comb begin
    handshake = vecValid_q & backbone_J_vec_tready;
    wrEn      = backbone_J_tvalid &
                ((state_q == FILL) | ((state_q == IDLE) & frame_start));
    wrIdx     = frame_start ? '0 : fillIdx_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      fillIdx_q      <= '0;
      vecValid_q     <= 1'b0;
      overrun_q      <= 1'b0;
      shortFrame_q   <= 1'b0;
      pendingStart_q <= 1'b0;
    end else begin
      overrun_q    <= 1'b0;
      shortFrame_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (frame_start) begin
            state_q   <= FILL;
            fillIdx_q <= '0;
          end else if (backbone_J_tvalid) begin
            overrun_q <= 1'b1;
          end
        end
        FILL: begin
          if (frame_start) begin
            shortFrame_q <= 1'b1;
            fillIdx_q    <= '0;
          end
        end
        HOLD: begin
          if (backbone_J_tvalid) begin
            overrun_q <= 1'b1;
          end
          if (handshake) begin
            vecValid_q     <= 1'b0;
            pendingStart_q <= 1'b0;
            fillIdx_q      <= '0;
            state_q        <= (pendingStart_q | frame_start) ? FILL : IDLE;
          end else if (frame_start) begin
            pendingStart_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
      // Word acceptance overrides the per-state index update above.
      if (wrEn) begin
        if (wrIdx == LAST_IDX) begin
          state_q    <= HOLD;
          vecValid_q <= 1'b1;
          fillIdx_q  <= '0;
        end else begin
          fillIdx_q  <= wrIdx + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N; k++) begin
        slot_q[k] <= '0;
      end
    end else if (wrEn) begin
      for (int k = 0; k < N; k++) begin
        if (wrIdx == IDX_WIDTH'(k)) begin
          slot_q[k] <= backbone_J;
        end
      end
    end
  end

  always_comb begin
    backbone_J_vec = '0;
    for (int k = 0; k < N; k++) begin
      backbone_J_vec[k*DATAWIDTH +: DATAWIDTH] = slot_q[k];
    end
  end

  assign backbone_J_vec_tvalid = vecValid_q;
  assign fill_idx              = fillIdx_q;
  assign overrun               = overrun_q;
  assign short_frame           = shortFrame_q;

endmodule

// File: tb/tb_backbone_j_collect.sv
// Drives a J=4 and a J=2 collector with identical stimulus and compares both against
// a frame-level reference model every cycle.
module tb_backbone_j_collect;

  logic        clk = 1'b0;
  logic        rst;
  logic        frameStart;
  logic        tvalid;
  logic [31:0] data;
  logic        tready;

  logic [95:0] vec0;
  logic        vecValid0;
  logic [2:0]  fill0;
  logic        overrun0;
  logic        short0;

  logic [31:0] vec1;
  logic        vecValid1;
  logic [1:0]  fill1;
  logic        overrun1;
  logic        short1;

  int compared   = 0;
  int mismatched = 0;

  int unsigned mN [2] = '{3, 1};
  bit          mOpen [2];
  bit          mHeld [2];
  bit          mPend [2];
  bit          mOvr [2];
  bit          mShort [2];
  int          mCount [2];
  logic [31:0] mSlot [2][3];

  backbone_j_collect #(.J(4), .DATAWIDTH(32)) dut4 (
    .clk(clk), .rst(rst), .frame_start(frameStart), .backbone_J_tvalid(tvalid),
    .backbone_J(data), .backbone_J_vec(vec0), .backbone_J_vec_tvalid(vecValid0),
    .backbone_J_vec_tready(tready), .fill_idx(fill0), .overrun(overrun0),
    .short_frame(short0)
  );

  backbone_j_collect #(.J(2), .DATAWIDTH(32)) dut2 (
    .clk(clk), .rst(rst), .frame_start(frameStart), .backbone_J_tvalid(tvalid),
    .backbone_J(data), .backbone_J_vec(vec1), .backbone_J_vec_tvalid(vecValid1),
    .backbone_J_vec_tready(tready), .fill_idx(fill1), .overrun(overrun1),
    .short_frame(short1)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s at %0t: observed %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 2; i++) begin
      mOpen[i] = 0; mHeld[i] = 0; mPend[i] = 0; mOvr[i] = 0; mShort[i] = 0; mCount[i] = 0;
      for (int k = 0; k < 3; k++) mSlot[i][k] = '0;
    end
  endtask

  // Frame-level view: a frame is a list of words; it completes once N words are in.
  task automatic modelStep(input bit fs, input bit tv, input logic [31:0] d, input bit rdy);
    for (int i = 0; i < 2; i++) begin
      bit ovr = 0;
      bit sh = 0;
      if (mHeld[i]) begin
        if (tv) ovr = 1;
        if (rdy) begin
          mHeld[i] = 0;
          mOpen[i] = mPend[i] || fs;
          mCount[i] = 0;
          mPend[i] = 0;
        end else if (fs) begin
          mPend[i] = 1;
        end
      end else begin
        if (fs) begin
          sh = mOpen[i];
          mOpen[i] = 1;
          mCount[i] = 0;
        end
        if (tv) begin
          if (mOpen[i]) begin
            mSlot[i][mCount[i]] = d;
            mCount[i]++;
          end else begin
            ovr = 1;
          end
        end
        if (mOpen[i] && mCount[i] == int'(mN[i])) begin
          mHeld[i] = 1;
          mOpen[i] = 0;
          mCount[i] = 0;
        end
      end
      mOvr[i] = ovr;
      mShort[i] = sh;
    end
  endtask

  task automatic checkCycle(input string where);
    checkOutput({where, " vec4"}, {32'b0, vec0}, {32'b0, mSlot[0][2], mSlot[0][1], mSlot[0][0]});
    checkOutput({where, " valid4"}, 128'(vecValid0), 128'(mHeld[0]));
    checkOutput({where, " fill4"}, 128'(fill0), 128'(mCount[0]));
    checkOutput({where, " overrun4"}, 128'(overrun0), 128'(mOvr[0]));
    checkOutput({where, " short4"}, 128'(short0), 128'(mShort[0]));
    checkOutput({where, " vec2"}, {96'b0, vec1}, {96'b0, mSlot[1][0]});
    checkOutput({where, " valid2"}, 128'(vecValid1), 128'(mHeld[1]));
    checkOutput({where, " fill2"}, 128'(fill1), 128'(mCount[1]));
    checkOutput({where, " overrun2"}, 128'(overrun1), 128'(mOvr[1]));
    checkOutput({where, " short2"}, 128'(short1), 128'(mShort[1]));
  endtask

  // Outputs are checked at the falling edge, then the next cycle's inputs are driven.
  task automatic applyStimulus(input bit fs, input bit tv, input logic [31:0] d, input bit rdy);
    @(negedge clk);
    checkCycle("cyc");
    frameStart = fs;
    tvalid = tv;
    data = d;
    tready = rdy;
    modelStep(fs, tv, d, rdy);
  endtask

  task automatic doReset();
    @(negedge clk);
    checkCycle("cyc");
    rst = 1'b1;
    frameStart = 0; tvalid = 0; data = '0; tready = 0;
    modelReset();
    #1;
    checkCycle("async rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    frameStart = 0; tvalid = 0; data = '0; tready = 0;
    modelReset();
    #12;
    rst = 1'b0;

    // Back-to-back frame with downstream always ready.
    applyStimulus(1, 0, 32'h0, 1);
    applyStimulus(0, 1, 32'h11, 1);
    applyStimulus(0, 1, 32'h22, 1);
    applyStimulus(0, 1, 32'h33, 1);
    applyStimulus(0, 0, 32'h0, 1);
    checkOutput("tp1 vec", {32'b0, vec0}, {32'b0, 96'h00000033_00000022_00000011});
    checkOutput("tp1 valid", 128'(vecValid0), 128'(1'b1));
    applyStimulus(0, 0, 32'h0, 1);

    // Gapped words and a stalled consumer.
    applyStimulus(1, 0, 32'h0, 0);
    for (int w = 0; w < 3; w++) begin
      applyStimulus(0, 1, 32'hC0 + 32'(w), 0);
      applyStimulus(0, 0, 32'h0, 0);
      applyStimulus(0, 0, 32'h0, 0);
    end
    for (int c = 0; c < 5; c++) applyStimulus(0, 0, 32'h0, 0);
    applyStimulus(0, 0, 32'h0, 1);
    applyStimulus(0, 0, 32'h0, 0);

    // Restart in mid-fill.
    applyStimulus(1, 0, 32'h0, 1);
    applyStimulus(0, 1, 32'hA1, 1);
    applyStimulus(0, 1, 32'hA2, 1);
    applyStimulus(1, 1, 32'hB1, 1);
    applyStimulus(0, 1, 32'hB2, 1);
    applyStimulus(0, 1, 32'hB3, 1);
    applyStimulus(0, 0, 32'h0, 1);

    // Extra word and frame_start while held, then accept.
    applyStimulus(1, 0, 32'h0, 0);
    applyStimulus(0, 1, 32'h1, 0);
    applyStimulus(0, 1, 32'h2, 0);
    applyStimulus(0, 1, 32'h3, 0);
    applyStimulus(0, 1, 32'hFF, 0);
    applyStimulus(1, 0, 32'h0, 0);
    applyStimulus(0, 0, 32'h0, 1);
    applyStimulus(0, 1, 32'h4, 0);
    applyStimulus(0, 1, 32'h5, 0);
    applyStimulus(0, 1, 32'h6, 1);
    applyStimulus(0, 0, 32'h0, 1);

    // Stray word with no frame open.
    applyStimulus(0, 1, 32'h55, 1);
    applyStimulus(0, 0, 32'h0, 1);

    // Reset in mid-frame, then a clean frame.
    applyStimulus(1, 0, 32'h0, 1);
    applyStimulus(0, 1, 32'h71, 1);
    applyStimulus(0, 1, 32'h72, 1);
    doReset();
    applyStimulus(1, 1, 32'h81, 1);
    applyStimulus(0, 1, 32'h82, 1);
    applyStimulus(0, 1, 32'h83, 1);
    applyStimulus(0, 0, 32'h0, 1);

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 199) == 0) begin
        doReset();
      end else begin
        applyStimulus($urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1,
                      $urandom, $urandom_range(0, 2) != 0);
      end
    end
    applyStimulus(0, 0, 32'h0, 0);
    @(negedge clk);
    checkCycle("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
